imm_ext_arbiter: RTL and testbench

Shares one registered immediate-extension unit between two requesters: port 0 is the decode stage (I-type ALU immediates) and port 1 is the load/store address unit (offsets). A round-robin arbiter accepts requests through valid/ready handshakes. Each request carries an extension mode, and each result is returned on one output channel tagged with the requester ID and a caller tag. The block sits between decode/AGU and the execute-stage operand muxes.

---
 rtl/imm_ext_arbiter_pkg.sv | 15 +
 rtl/imm_ext_arbiter_core.sv | 35 +++
 rtl/imm_ext_arbiter.sv | 106 ++++++++++
 tb/tb_imm_ext_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_arbiter_pkg.sv
// Shared definitions for the immediate-extension arbiter.
// Extension mode codes and response FSM state encoding.
package imm_ext_arbiter_pkg;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_RSVD = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/imm_ext_arbiter_core.sv
// imm_ext_core: combinational immediate extender.
// Ports: imm, mode in; data, bad_mode out. LUI under `IMM_EXT_LUI_EN.
module imm_ext_core
  import imm_ext_arbiter_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data,
  output logic              bad_mode
);

  logic [DATA_W-1:0] w_sign;

  assign w_sign = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    data     = w_sign;
    bad_mode = 1'b0;
    unique case (mode)
      EXT_SIGN: data = w_sign;
      EXT_ZERO: data = {{(DATA_W-IMM_W){1'b0}}, imm};
`ifdef IMM_EXT_LUI_EN
      EXT_LUI:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
`else
      EXT_LUI:  bad_mode = 1'b1;
`endif
      EXT_RSVD: bad_mode = 1'b1;
      default:  bad_mode = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one registered immediate
// extender between decode (port 0) and AGU (port 1). Ports: clk,
// rst_n, req_valid/ready[1:0], req_imm/mode/tag_{0,1}, rsp_valid,
// rsp_ready, rsp_data/id/tag/bad_mode. Macro: IMM_EXT_LUI_EN.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [IMM_W-1:0]  req_imm_0,
  input  logic [IMM_W-1:0]  req_imm_1,
  input  logic [1:0]        req_mode_0,
  input  logic [1:0]        req_mode_1,
  input  logic [TAG_W-1:0]  req_tag_0,
  input  logic [TAG_W-1:0]  req_tag_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_bad_mode
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic              r_id;
  logic [TAG_W-1:0]  r_tag;
  logic              r_bad;

  logic [1:0]        w_grant;
  logic              w_can_accept;
  logic              w_xfer;
  logic              w_gid;
  logic [IMM_W-1:0]  w_imm;
  logic [1:0]        w_mode;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data;
  logic              w_bad;

  // Contention goes to the port that did not win last time.
  assign w_grant[0] = req_valid[0] & (~req_valid[1] | r_last);
  assign w_grant[1] = req_valid[1] & (~req_valid[0] | ~r_last);

  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
  assign req_ready    = w_grant & {2{w_can_accept}};
  assign w_xfer       = |req_ready;
  assign w_gid        = req_ready[1];

  assign w_imm  = w_gid ? req_imm_1  : req_imm_0;
  assign w_mode = w_gid ? req_mode_1 : req_mode_0;
  assign w_tag  = w_gid ? req_tag_1  : req_tag_0;

  imm_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm      (w_imm),
    .mode     (w_mode),
    .data     (w_data),
    .bad_mode (w_bad)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_last  <= 1'b1;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_tag   <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_last <= w_gid;
        r_data <= w_data;
        r_id   <= w_gid;
        r_tag  <= w_tag;
        r_bad  <= w_bad;
      end
    end
  end

  assign rsp_valid    = (r_state == ST_FULL);
  assign rsp_data     = r_data;
  assign rsp_id       = r_id;
  assign rsp_tag      = r_tag;
  assign rsp_bad_mode = r_bad;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter.
// Vector table plus directed multi-cycle sequences.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_imm_0 = '0, req_imm_1 = '0;
  logic [1:0]  req_mode_0 = '0, req_mode_1 = '0;
  logic [3:0]  req_tag_0 = '0, req_tag_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_bad_mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_imm_0    (req_imm_0),
    .req_imm_1    (req_imm_1),
    .req_mode_0   (req_mode_0),
    .req_mode_1   (req_mode_1),
    .req_tag_0    (req_tag_0),
    .req_tag_1    (req_tag_1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_tag      (rsp_tag),
    .rsp_bad_mode (rsp_bad_mode)
  );

  typedef struct {
    bit          port;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    bit          exp_bad;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(bit p, logic [15:0] imm, logic [1:0] md,
                       logic [3:0] tg);
    if (p) begin
      req_imm_1 = imm; req_mode_1 = md; req_tag_1 = tg;
    end else begin
      req_imm_0 = imm; req_mode_0 = md; req_tag_0 = tg;
    end
  endtask

  logic [31:0] held_data;
  logic [3:0]  held_tag;

  initial begin
    vecs[0] = '{1'b0, 16'h8001, 2'b00, 4'd3, 32'hFFFF8001, 1'b0};
    vecs[1] = '{1'b1, 16'h8001, 2'b01, 4'd5, 32'h00008001, 1'b0};
`ifdef IMM_EXT_LUI_EN
    vecs[2] = '{1'b1, 16'h8001, 2'b10, 4'd6, 32'h80010000, 1'b0};
`else
    vecs[2] = '{1'b1, 16'h8001, 2'b10, 4'd6, 32'hFFFF8001, 1'b1};
`endif
    vecs[3] = '{1'b0, 16'h7FFF, 2'b11, 4'd9, 32'h00007FFF, 1'b1};
    vecs[4] = '{1'b0, 16'h0001, 2'b00, 4'd1, 32'h00000001, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 2'b01, 4'd2, 32'h0000FFFF, 1'b0};

    do_reset();
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_bad", {31'd0, rsp_bad_mode}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);

    // Contention straight after reset: 0,1,0,1
    @(negedge clk);
    drive(1'b0, 16'h0010, 2'b00, 4'hA);
    drive(1'b1, 16'h0020, 2'b00, 4'hB);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("cont_valid", {31'd0, rsp_valid}, 32'd1);
      chk("cont_id", {31'd0, rsp_id}, i % 2);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("cont_drain", {31'd0, rsp_valid}, 32'd0);

    // Table of single requests
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].port, vecs[i].imm, vecs[i].mode, vecs[i].tag);
      req_valid = vecs[i].port ? 2'b10 : 2'b01;
      rsp_ready = 1'b1;
      #1;
      chk("vec_ready", {30'd0, req_ready},
          vecs[i].port ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("vec_valid", {31'd0, rsp_valid}, 32'd1);
      chk("vec_data", rsp_data, vecs[i].exp_data);
      chk("vec_id", {31'd0, rsp_id}, {31'd0, vecs[i].port});
      chk("vec_tag", {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
      chk("vec_bad", {31'd0, rsp_bad_mode}, {31'd0, vecs[i].exp_bad});
      @(posedge clk); #1;
      chk("vec_drain", {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure while FULL
    @(negedge clk);
    drive(1'b0, 16'h1234, 2'b00, 4'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 16'h00AA, 2'b01, 4'd8);
    req_valid = 2'b10;
    held_data = 32'h00001234;
    held_tag  = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, held_data);
      chk("bp_tag", {28'd0, rsp_tag}, {28'd0, held_tag});
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_next_id", {31'd0, rsp_id}, 32'd1);
    chk("bp_next_data", rsp_data, 32'h000000AA);
    chk("bp_next_tag", {28'd0, rsp_tag}, 32'd8);
    @(posedge clk); #1;

    // Reset mid-stream; last grant before it was port 1
    @(negedge clk);
    drive(1'b1, 16'h0055, 2'b00, 4'd4);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("mr_full", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_async_data", rsp_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_no_partial", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    drive(1'b0, 16'h0001, 2'b00, 4'd1);
    drive(1'b1, 16'h0002, 2'b00, 4'd2);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    chk("mr_first_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("mr_first_id", {31'd0, rsp_id}, 32'd0);
    chk("mr_first_tag", {28'd0, rsp_tag}, 32'd1);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
